// File: rtl/coffee_vending_ctrl.sv
// rtl/coffee_vending_ctrl.sv - coin credit, drink pricing and timed recipe controller for the coffee machine
module coffee_vending_ctrl #(
    parameter int CREDIT_W    = 11,
    parameter int MAX_CREDIT  = 1500,
    parameter int NUM_DRINKS  = 4,
    localparam int SEL_W      = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1,
    parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICES = {11'd1000, 11'd800, 11'd600, 11'd500},
    parameter logic [NUM_DRINKS*20-1:0] RECIPE = {20'h32012, 20'h02122, 20'h00123, 20'h00023},
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_100,
    input  logic                coin_500,
    input  logic [SEL_W-1:0]    drink_sel,
    input  logic                start,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] change,
    output logic [4:0]          ingredient,
    output logic                busy,
    output logic                finished,
    output logic                coin_reject,
    output logic                insufficient
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPENSE = 2'd1;
    localparam logic [1:0] S_DONE     = 2'd2;

    // Step index 5 means "no further ingredient in this recipe".
    localparam logic [2:0] STEP_NONE = 3'd5;

    logic [1:0]          state;
    logic [SEL_W-1:0]    drink;
    logic [2:0]          step;
    logic [3:0]          tick_cnt;
    logic [PW-1:0]       presc;

    logic                tick;
    logic                sel_valid;
    int                  sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic [2:0]          first_step;
    logic [2:0]          following_step;
    logic [3:0]          cur_dur;
    logic [CREDIT_W:0]   sum5;
    logic [CREDIT_W:0]   after5;
    logic [CREDIT_W:0]   sum1;
    logic [CREDIT_W:0]   coin_sum;
    logic                acc5;
    logic                acc1;
    logic                coin_rej;

    function automatic logic [3:0] dur_of(input int d, input int k);
        return RECIPE[(d*5 + k)*4 +: 4];
    endfunction

    // First ingredient at or after 'from' with a nonzero duration.
    function automatic logic [2:0] next_nz(input int d, input int from);
        logic [2:0] r;
        r = STEP_NONE;
        for (int k = 4; k >= 0; k--) begin
            if (k >= from && dur_of(d, k) != 4'd0) begin
                r = 3'(k);
            end
        end
        return r;
    endfunction

    // Drink lookup, recipe sequencing and coin acceptance (500 first, then 100 on the updated sum).
    always_comb begin
        tick           = (presc == PW'(TICK_CYCLES - 1));
        sel_valid      = (int'(drink_sel) < NUM_DRINKS);
        sel_idx        = sel_valid ? int'(drink_sel) : 0;
        sel_price      = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
        first_step     = next_nz(sel_idx, 0);
        following_step = next_nz(int'(drink), int'(step) + 1);
        cur_dur        = dur_of(int'(drink), int'(step));
        sum5           = {1'b0, credit} + (CREDIT_W+1)'(500);
        acc5           = coin_500 && (sum5 <= (CREDIT_W+1)'(MAX_CREDIT));
        after5         = acc5 ? sum5 : {1'b0, credit};
        sum1           = after5 + (CREDIT_W+1)'(100);
        acc1           = coin_100 && (sum1 <= (CREDIT_W+1)'(MAX_CREDIT));
        coin_sum       = acc1 ? sum1 : after5;
        coin_rej       = (coin_500 && !acc5) || (coin_100 && !acc1);
    end

    // Main controller: credit handling in IDLE, timed valve sequencing in DISPENSE, one-tick finish in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            drink        <= '0;
            step         <= '0;
            tick_cnt     <= '0;
            presc        <= '0;
            credit       <= '0;
            change       <= '0;
            ingredient   <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cancel) begin
                        change      <= credit;
                        credit      <= '0;
                        coin_reject <= coin_100 | coin_500;
                    end else if (start) begin
                        coin_reject <= coin_100 | coin_500;
                        if (sel_valid && credit >= sel_price) begin
                            drink    <= SEL_W'(sel_idx);
                            change   <= credit - sel_price;
                            credit   <= '0;
                            presc    <= '0;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                            if (first_step == STEP_NONE) begin
                                state      <= S_DONE;
                                finished   <= 1'b1;
                                ingredient <= '0;
                            end else begin
                                state      <= S_DISPENSE;
                                step       <= first_step;
                                ingredient <= 5'b00001 << first_step;
                            end
                        end else begin
                            insufficient <= 1'b1;
                        end
                    end else begin
                        credit      <= coin_sum[CREDIT_W-1:0];
                        coin_reject <= coin_rej;
                        if (acc5 || acc1) begin
                            change <= '0;
                        end
                    end
                end
                S_DISPENSE: begin
                    coin_reject <= coin_100 | coin_500;
                    if (tick) begin
                        presc <= '0;
                        if (tick_cnt + 4'd1 == cur_dur) begin
                            tick_cnt <= '0;
                            if (following_step == STEP_NONE) begin
                                state      <= S_DONE;
                                finished   <= 1'b1;
                                ingredient <= '0;
                            end else begin
                                step       <= following_step;
                                ingredient <= 5'b00001 << following_step;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                S_DONE: begin
                    coin_reject <= coin_100 | coin_500;
                    if (tick) begin
                        presc    <= '0;
                        state    <= S_IDLE;
                        finished <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    finished   <= 1'b0;
                    ingredient <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coffee_vending_ctrl.sv
// tb/tb_coffee_vending_ctrl.sv - directed self-checking bench for coffee_vending_ctrl
module tb_coffee_vending_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        coin_100 = 1'b0;
    logic        coin_500 = 1'b0;
    logic [1:0]  drink_sel = 2'd0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [10:0] credit;
    logic [10:0] change;
    logic [4:0]  ingredient;
    logic        busy;
    logic        finished;
    logic        coin_reject;
    logic        insufficient;

    int tests = 0;
    int fails = 0;

    // Drink 0: water 2, coffee 1, milk 1. Drink 1: empty recipe. Drink 2: one tick each. Drink 3: water 1, coffee 2.
    coffee_vending_ctrl #(
        .CREDIT_W(11),
        .MAX_CREDIT(1500),
        .NUM_DRINKS(4),
        .PRICES({11'd1000, 11'd800, 11'd600, 11'd500}),
        .RECIPE({20'h00021, 20'h11111, 20'h00000, 20'h01012}),
        .TICK_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .coin_100(coin_100),
        .coin_500(coin_500),
        .drink_sel(drink_sel),
        .start(start),
        .cancel(cancel),
        .credit(credit),
        .change(change),
        .ingredient(ingredient),
        .busy(busy),
        .finished(finished),
        .coin_reject(coin_reject),
        .insufficient(insufficient)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge; returns at the negedge after that edge.
    task automatic cyc(input logic c1, input logic c5, input logic st, input logic cn, input logic [1:0] sel);
        @(negedge clock);
        coin_100  = c1;
        coin_500  = c5;
        start     = st;
        cancel    = cn;
        drink_sel = sel;
        @(negedge clock);
        coin_100  = 1'b0;
        coin_500  = 1'b0;
        start     = 1'b0;
        cancel    = 1'b0;
        drink_sel = 2'd0;
    endtask

    initial begin
        logic [4:0] exp_ing;
        logic       exp_fin;
        logic       exp_busy;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst credit", credit, 0);
        check("rst change", change, 0);
        check("rst ingredient", ingredient, 0);
        check("rst busy", busy, 0);
        check("rst finished", finished, 0);
        check("rst coin_reject", coin_reject, 0);
        check("rst insufficient", insufficient, 0);
        reset = 1'b0;

        // Coin accumulation
        cyc(0, 1, 0, 0, 0);
        check("c500 credit", credit, 500);
        check("c500 reject", coin_reject, 0);
        cyc(0, 1, 0, 0, 0);
        check("c500b credit", credit, 1000);
        check("c500b reject", coin_reject, 0);
        cyc(1, 0, 0, 0, 0);
        check("c100 credit", credit, 1100);
        check("c100 reject", coin_reject, 0);

        // Dispense drink 0 with coin+start injected mid-coffee
        cyc(0, 0, 1, 0, 0);
        check("buy change", change, 600);
        check("buy credit", credit, 0);
        check("buy busy", busy, 1);
        check("buy ingr0", ingredient, 5'b00001);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            exp_ing  = (n < 8) ? 5'b00001 : (n < 12) ? 5'b00010 : (n < 16) ? 5'b01000 : 5'b00000;
            exp_fin  = (n >= 16 && n < 20);
            exp_busy = (n < 20);
            check($sformatf("disp ingr n=%0d", n), ingredient, exp_ing);
            check($sformatf("disp fin n=%0d", n), finished, exp_fin);
            check($sformatf("disp busy n=%0d", n), busy, exp_busy);
            if (n == 9) begin
                check("disp coin_reject", coin_reject, 1);
                check("disp insufficient", insufficient, 0);
                coin_500 = 1'b0;
                start    = 1'b0;
            end
            if (n == 8) begin
                coin_500 = 1'b1;
                start    = 1'b1;
            end
        end
        check("post change", change, 600);
        check("post credit", credit, 0);

        // Ceiling
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("full credit", credit, 1500);
        check("full change cleared", change, 0);
        cyc(1, 0, 0, 0, 0);
        check("over reject", coin_reject, 1);
        check("over credit", credit, 1500);
        cyc(0, 0, 0, 1, 0);
        check("cancel1 change", change, 1500);
        check("cancel1 credit", credit, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("both reject", coin_reject, 1);
        check("both credit", credit, 1500);
        cyc(0, 0, 0, 1, 0);
        check("cancel2 credit", credit, 0);

        // Insufficient credit then cancel
        cyc(0, 1, 0, 0, 0);
        check("500 change cleared", change, 0);
        cyc(0, 0, 1, 0, 3);
        check("insuf pulse", insufficient, 1);
        check("insuf credit", credit, 500);
        check("insuf busy", busy, 0);
        @(negedge clock);
        check("insuf one cycle", insufficient, 0);
        cyc(0, 0, 0, 1, 0);
        check("cancel3 change", change, 500);
        check("cancel3 credit", credit, 0);

        // start + cancel + coin together: cancel wins, coin rejected
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        check("sc change", change, 500);
        check("sc credit", credit, 0);
        check("sc busy", busy, 0);
        check("sc reject", coin_reject, 1);

        // Empty recipe drink 1 (price 600)
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("pre empty credit", credit, 700);
        cyc(0, 0, 1, 0, 1);
        check("empty change", change, 100);
        check("empty fin0", finished, 1);
        check("empty busy0", busy, 1);
        check("empty ingr0", ingredient, 0);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            check($sformatf("empty fin n=%0d", n), finished, (n < 4));
            check($sformatf("empty busy n=%0d", n), busy, (n < 4));
            check($sformatf("empty ingr n=%0d", n), ingredient, 0);
        end

        // Reset mid-water
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("rw change", change, 500);
        @(negedge clock);
        @(negedge clock);
        check("rw water", ingredient, 5'b00001);
        #2 reset = 1'b1;
        #1;
        check("rw ingr", ingredient, 0);
        check("rw credit", credit, 0);
        check("rw change0", change, 0);
        check("rw busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0);
        check("after rst credit", credit, 100);
        check("after rst busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coffee_vending_ctrl.md
Name: coffee_vending_ctrl

Overview:
- Parametrised next-generation controller for the coffee machine.
- Accumulates credit from 100- and 500-unit coin pulses and supports NUM_DRINKS drink types, each with a price from a table.
- On a start request it deducts the price, reports change, and runs a timed five-ingredient recipe (water, coffee, sugar, milk, chocolate), with per-drink durations in ticks.
- Sits between the debounced button/switch inputs and the 7-segment display and valve drivers.

Parameters:
- CREDIT_W, 11, credit/change width in units (max credit 2047).
- MAX_CREDIT, 1500, credit ceiling; a coin that would exceed it is rejected.
- NUM_DRINKS, 4, number of selectable drinks; sel width SEL_W = clog2(NUM_DRINKS), minimum 1.
- PRICES, packed NUM_DRINKS x CREDIT_W, price of drink i in slice i. Default {1000, 800, 600, 500}, with drink 0 in the LSB slice = 500.
- RECIPE, packed NUM_DRINKS x 5 x 4 bits, duration in ticks of ingredient k of drink i, with k=0 being water. 0 means the ingredient is skipped.
- TICK_CYCLES, 50_000_000, clock cycles per tick (1 s at 50 MHz).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- coin_100  in  1  single-cycle pulse, +100.
- coin_500  in  1  single-cycle pulse, +500.
- drink_sel  in  SEL_W  drink index, sampled on start.
- start  in  1  single-cycle pulse: request dispense.
- cancel  in  1  single-cycle pulse: refund credit while idle.
- credit  out  CREDIT_W  current credit.
- change  out  CREDIT_W  change/refund amount, held until the next accepted coin or start.
- ingredient  out  5  one-hot active valve: bit0 water, bit1 coffee, bit2 sugar, bit3 milk, bit4 chocolate.
- busy  out  1  high in DISPENSE and DONE.
- finished  out  1  high for exactly one tick duration in DONE.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- insufficient  out  1  one-cycle pulse when start is refused.

Behaviour:
- Reset (async): state IDLE; credit=0, change=0, ingredient=0, busy=0, finished=0, coin_reject=0, insufficient=0; tick prescaler=0, step=0.
- States: IDLE, DISPENSE, DONE.
- IDLE coin handling: a coin is added if credit+value <= MAX_CREDIT; otherwise credit is unchanged and coin_reject pulses. If both coins arrive in the same cycle, coin_500 is evaluated first, then coin_100 against the updated sum, so each may be independently accepted or rejected. An accepted coin clears change to 0 in the same cycle.
- IDLE start with credit >= PRICES[drink_sel] and drink_sel < NUM_DRINKS: latch the drink, set change = credit - price, credit=0, step=first ingredient with nonzero duration, clear the prescaler, go to DISPENSE next cycle. If all five durations are 0, go directly to DONE.
- IDLE start with credit < price or an invalid sel: insufficient pulses; credit is unchanged.
- IDLE cancel: change=credit, credit=0. If start and cancel arrive in the same cycle, cancel wins. A coin in the same cycle as start or cancel is ignored and rejected (coin_reject pulses).
- DISPENSE: ingredient = one-hot(step), registered. The prescaler counts 0..TICK_CYCLES-1 and produces a tick on wrap. A tick counter compares against RECIPE[drink][step]. When it matches, advance to the next nonzero step, skipping zeros, and reset the tick counter. After the last step go to DONE. Ingredient switches with no gap cycle.
- DISPENSE and DONE: coins are rejected (coin_reject pulses); start, cancel and insufficient are ignored.
- DONE: ingredient=0, finished=1 for one tick, then IDLE with finished=0. busy drops when IDLE is entered.
- Reset mid-dispense: all valves close asynchronously and the credit is lost (no refund); this is intentional.
- Arithmetic is unsigned. Credit never exceeds MAX_CREDIT, and change is never negative.

Test Plan:
- Reset, then coin_500, coin_500, coin_100 → credit 500, 1000, 1100; pulse coin_reject never asserted.
- TICK_CYCLES=4, credit 1100, drink 0 (price 500), start → change=600, credit=0. Ingredients follow the RECIPE durations × 4 cycles each, zero-duration steps skipped; then finished high 4 cycles; busy low after.
- credit 1500, coin_100 → coin_reject pulse, credit stays 1500; coin_100 and coin_500 in the same cycle at credit 1000 → 500 accepted, 100 rejected, credit 1500.
- credit 500, select drink 3 (price 1000), start → insufficient pulse, credit 500, state IDLE; then cancel → change=500, credit=0.
- During DISPENSE, pulse coin_500 and start → coin_reject pulse, dispense timing unaltered; assert reset mid-water → ingredient=0 immediately, credit=0.
- Drink whose RECIPE is all zero, with enough credit → DONE directly: finished for one tick, ingredient never nonzero.
